pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
// Parametrised pipeline stage register between two CPU stages (D->E, E->M, M->W).
// Replaces fixed per-stage registers with one block carrying a data bus, a control bus and PC.
// Adds valid/ready flow control, flush, bubble insertion and a stall-cycle counter.
// Adds an optional 2-entry skid mode that cuts the combinational ready path.
// PARAMETERS
// DATA_W  96  width of the packed datapath payload (e.g. RD1|RD2|EXT)
// CTRL_W  24  width of the packed control payload; all-zero encodes a NOP
// SKID    0   0 = single entry, pass-through ready; 1 = 2-entry skid buffer, registered ready
// CNT_W   16  width of the stall-cycle counter
// PORTS
// clk        in   1       clock; all state updates on its rising edge
// reset      in   1       synchronous, active-high reset
// in_valid   in   1       upstream stage presents a transaction
// in_ready   out  1       this stage accepts the transaction this cycle
// in_data    in   DATA_W  datapath payload
// in_ctrl    in   CTRL_W  control payload
// in_pc      in   32      PC of the instruction
// bubble     in   1       on an accepted transaction, store ctrl=0 and data=0 (PC kept)
// flush      in   1       discard all held entries and any incoming transaction
// out_valid  out  1       head entry valid
// out_ready  in   1       downstream consumes the head entry
// out_data   out  DATA_W  head datapath payload
// out_ctrl   out  CTRL_W  head control payload
// out_pc     out  32      head PC
// stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, out_ctrl=0, out_pc=0, stall_cnt=0, occupancy=0.
//   in_ready=1 from the first cycle after reset.
// - Handshakes:
//   - Input transfer when in_valid & in_ready.
//   - Output transfer when out_valid & out_ready.
//   - Latency: an accepted transaction appears on out_* in the next cycle.
// - Entry order is FIFO. out_* always shows the head entry. out_* are registers and hold stable while out_valid & !out_ready.
// - SKID=0:
//   - One entry.
//   - in_ready = !out_valid | out_ready (combinational).
//   - Simultaneous in/out transfers replace the head with no bubble.
// - SKID=1: states EMPTY/ONE/TWO; in_ready = (state!=TWO), registered.
//   - EMPTY: in xfer -> ONE.
//   - ONE: in & out xfer -> ONE (head replaced); in only -> TWO (goes to skid); out only -> EMPTY.
//   - TWO: out xfer -> ONE (skid moves to head, same cycle); in_ready=0, so no input transfer.
// - bubble:
//   - Only acts on an accepted input transfer.
//   - The stored entry has ctrl=0, data=0, pc=in_pc and valid=1.
//   - A NOP therefore advances through the pipeline.
// - flush:
//   - Highest priority after reset.
//   - Next cycle: occupancy 0, out_valid=0, out_ctrl=0, out_data=0, out_pc=0.
//   - An input presented in the flush cycle is dropped; in_ready still reads per mode.
// - stall_cnt: +1 each cycle with out_valid & !out_ready, saturating at 2^CNT_W-1. Cleared only by reset.
// - Flush and reset mid-stall: counting resumes from the current value (flush) or from 0 (reset).
// - No X on outputs after reset. Data in the empty skid slot is don't-care and is never visible.
// TESTING
// - T1, SKID=0, streaming: in_valid=1, out_ready=1, pc 0x3000,0x3004,0x3008.
//   -> out_pc follows 1 cycle later, no gaps; stall_cnt=0.
// - T2, SKID=1, backpressure: send 0x3000, 0x3004 with out_ready=0.
//   -> in_ready=0 after 2nd accept; out_pc holds 0x3000.
//   -> out_ready=1 gives 0x3000 then 0x3004; stall_cnt counts the held cycles exactly.
// - T3, bubble: in_ctrl=24'hABCDEF, in_data all-ones, pc=0x3010, bubble=1.
//   -> out_valid=1, out_ctrl=0, out_data=0, out_pc=0x3010.
// - T4, flush in TWO with an input pending.
//   -> next cycle out_valid=0, all out_*=0, in_ready=1; the pending input never appears.
// - T5, reset mid-stream, SKID=1, state TWO, stall_cnt=5.
//   -> after reset: all outputs 0, stall_cnt=0, in_ready=1.
// - T6, saturation, CNT_W=4: out_valid held with out_ready=0 for 20 cycles.
//   -> stall_cnt stops at 4'hF.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register between CPU stages carrying data, control and PC, with flush/bubble and stall counting.
// Latency: one cycle from an accepted input to out_*; out_* are always registered.
// Backpressure: SKID=0 passes out_ready through to in_ready; SKID=1 buffers 2 entries and registers in_ready.
module pipe_stage_buf #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 24,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [31:0]       in_pc,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  // One held instruction: PC, control word and datapath payload.
  typedef struct packed {
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t in_ent;
  entry_t head_q;
  logic   head_vld_q;
  logic   in_xfer;
  logic   out_xfer;

  // Incoming entry; a bubble turns it into a NOP but keeps the PC for tracing.
  always_comb begin
    in_ent      = '0;
    in_ent.pc   = in_pc;
    in_ent.ctrl = bubble ? '0 : in_ctrl;
    in_ent.data = bubble ? '0 : in_data;
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = head_vld_q & out_ready;

  assign out_valid = head_vld_q;
  assign out_data  = head_q.data;
  assign out_ctrl  = head_q.ctrl;
  assign out_pc    = head_q.pc;

  generate
    if (SKID == 0) begin : g_single
      // Ready is combinational: the single slot frees up in the same cycle it is consumed.
      assign in_ready = !head_vld_q | out_ready;

      // Single slot: load on accept (replacing a consumed head without a gap), clear on drain.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          head_vld_q <= 1'b0;
          head_q     <= '0;
        end else if (in_xfer) begin
          head_vld_q <= 1'b1;
          head_q     <= in_ent;
        end else if (out_xfer) begin
          head_vld_q <= 1'b0;
        end
      end
    end else begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } state_t;

      state_t state_q;
      entry_t skid_q;
      logic   rdy_q;

      // Ready comes straight from a flop, so the upstream never sees out_ready combinationally.
      assign in_ready = rdy_q;

      // Occupancy FSM: the head feeds out_*, the skid slot absorbs the one
      // extra transfer that arrives while ready is still registered high.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          state_q    <= EMPTY;
          head_vld_q <= 1'b0;
          head_q     <= '0;
          skid_q     <= '0;
          rdy_q      <= 1'b1;
        end else begin
          case (state_q)
            EMPTY: begin
              if (in_xfer) begin
                head_q     <= in_ent;
                head_vld_q <= 1'b1;
                state_q    <= ONE;
              end
            end
            ONE: begin
              if (in_xfer && out_xfer) begin
                head_q <= in_ent;
              end else if (in_xfer) begin
                skid_q  <= in_ent;
                state_q <= TWO;
                rdy_q   <= 1'b0;
              end else if (out_xfer) begin
                head_vld_q <= 1'b0;
                state_q    <= EMPTY;
              end
            end
            TWO: begin
              if (out_xfer) begin
                head_q  <= skid_q;
                state_q <= ONE;
                rdy_q   <= 1'b1;
              end
            end
            default: begin
              state_q    <= EMPTY;
              head_vld_q <= 1'b0;
              rdy_q      <= 1'b1;
            end
          endcase
        end
      end
    end
  endgenerate

  // Count cycles where the head is held by downstream; saturates, survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (head_vld_q && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (single entry, skid, skid with 4-bit counter) share one stimulus stream.
// Directed scenarios use fixed expected values; the random scenario compares against an occupancy/queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [95:0] in_data;
  logic [23:0] in_ctrl;
  logic [31:0] in_pc;
  logic        bubble;
  logic        flush;
  logic        out_ready;

  logic        ir [3];
  logic        ov [3];
  logic [95:0] od [3];
  logic [23:0] oc [3];
  logic [31:0] op [3];
  logic [15:0] sc [2];
  logic [3:0]  sc2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per instance an ordered list of held entries plus a stall count.
  int          mskid [3] = '{0, 1, 1};
  int          mcmax [3] = '{65535, 65535, 15};
  int          mn    [3];
  int          mcnt  [3];
  logic [31:0] mpc   [3][2];
  logic [23:0] mctrl [3][2];
  logic [95:0] mdat  [3][2];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(96), .CTRL_W(24), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .bubble(bubble), .flush(flush), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]), .out_pc(op[0]), .stall_cnt(sc[0]));

  pipe_stage_buf #(.DATA_W(96), .CTRL_W(24), .SKID(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .bubble(bubble), .flush(flush), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]), .out_pc(op[1]), .stall_cnt(sc[1]));

  pipe_stage_buf #(.DATA_W(96), .CTRL_W(24), .SKID(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .bubble(bubble), .flush(flush), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od[2]), .out_ctrl(oc[2]), .out_pc(op[2]), .stall_cnt(sc2));

  function automatic int dut_cnt(int k);
    return (k == 2) ? int'(sc2) : int'(sc[k]);
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit rdy, ix, ox;
      if (reset) begin
        mn[k]   = 0;
        mcnt[k] = 0;
        continue;
      end
      rdy = (mskid[k] != 0) ? (mn[k] < 2) : ((mn[k] == 0) || out_ready);
      ix  = in_valid && rdy;
      ox  = (mn[k] > 0) && out_ready;
      if ((mn[k] > 0) && !out_ready && (mcnt[k] < mcmax[k])) mcnt[k]++;
      if (flush) begin
        mn[k] = 0;
      end else begin
        if (ox) begin
          mpc[k][0]   = mpc[k][1];
          mctrl[k][0] = mctrl[k][1];
          mdat[k][0]  = mdat[k][1];
          mn[k]--;
        end
        if (ix) begin
          mpc[k][mn[k]]   = in_pc;
          mctrl[k][mn[k]] = bubble ? 24'd0 : in_ctrl;
          mdat[k][mn[k]]  = bubble ? 96'd0 : in_data;
          mn[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    in_pc     = '0;
    bubble    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    in_valid = 1'b1;
    in_pc    = 32'h0000_DEAD;
    in_ctrl  = 24'h123456;
    reset    = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (ov[k] !== 1'b0 || od[k] !== 96'd0 || oc[k] !== 24'd0 || op[k] !== 32'd0 ||
          dut_cnt(k) !== 0 || ir[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset dut%0d: valid=%b data=%h ctrl=%h pc=%h cnt=%0d ready=%b, want all 0 and ready=1",
                 k, ov[k], od[k], oc[k], op[k], dut_cnt(k), ir[k]);
      end
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] pc;
      pc      = 32'h3000 + 32'(4 * i);
      in_pc   = pc;
      in_ctrl = 24'(i + 1);
      tick();
      n_tests++;
      if (ov[0] !== 1'b1 || op[0] !== pc || oc[0] !== 24'(i + 1) || ir[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b pc=%h ctrl=%h ready=%b, want 1 %h %h 1",
                 i, ov[0], op[0], oc[0], ir[0], pc, 24'(i + 1));
      end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (ov[0] !== 1'b0 || sc[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL stream_drain: valid=%b cnt=%0d, want 0 0", ov[0], sc[0]);
    end
  endtask

  task automatic test_backpressure();
    localparam int HOLD = 3;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3000;
    tick();
    n_tests++;
    if (ov[1] !== 1'b1 || op[1] !== 32'h3000 || ir[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: valid=%b pc=%h ready=%b, want 1 3000 1", ov[1], op[1], ir[1]);
    end
    in_pc = 32'h3004;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (ir[1] !== 1'b0 || op[1] !== 32'h3000) begin
      n_fail++;
      $display("FAIL bp_full: ready=%b pc=%h, want 0 3000", ir[1], op[1]);
    end
    for (int i = 0; i < HOLD; i++) tick();
    n_tests++;
    if (op[1] !== 32'h3000 || ov[1] !== 1'b1 || sc[1] !== 16'(1 + HOLD)) begin
      n_fail++;
      $display("FAIL bp_hold: pc=%h valid=%b cnt=%0d, want 3000 1 %0d", op[1], ov[1], sc[1], 1 + HOLD);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (op[1] !== 32'h3004 || ov[1] !== 1'b1 || ir[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: pc=%h valid=%b ready=%b, want 3004 1 1", op[1], ov[1], ir[1]);
    end
    tick();
    n_tests++;
    if (ov[1] !== 1'b0 || sc[1] !== 16'(1 + HOLD)) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b cnt=%0d, want 0 %0d", ov[1], sc[1], 1 + HOLD);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bubble    = 1'b1;
    in_ctrl   = 24'hABCDEF;
    in_data   = '1;
    in_pc     = 32'h3010;
    tick();
    in_valid = 1'b0;
    bubble   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (ov[k] !== 1'b1 || oc[k] !== 24'd0 || od[k] !== 96'd0 || op[k] !== 32'h3010) begin
        n_fail++;
        $display("FAIL bubble dut%0d: valid=%b ctrl=%h data=%h pc=%h, want 1 0 0 3010",
                 k, ov[k], oc[k], od[k], op[k]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3100;
    in_ctrl   = 24'h000011;
    tick();
    in_pc     = 32'h3104;
    tick();
    in_pc     = 32'h3BAD;
    in_ctrl   = 24'h0000EE;
    flush     = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if (ov[1] !== 1'b0 || od[1] !== 96'd0 || oc[1] !== 24'd0 || op[1] !== 32'd0 ||
        ir[1] !== 1'b1 || sc[1] !== 16'd2) begin
      n_fail++;
      $display("FAIL flush: valid=%b data=%h ctrl=%h pc=%h ready=%b cnt=%0d, want 0 0 0 0 1 2",
               ov[1], od[1], oc[1], op[1], ir[1], sc[1]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ov[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_after[%0d]: valid=%b pc=%h, want valid 0", i, ov[1], op[1]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3200;
    tick();
    in_pc     = 32'h3204;
    tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (sc[1] !== 16'd5 || ir[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pre: cnt=%0d ready=%b, want 5 0", sc[1], ir[1]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (ov[1] !== 1'b0 || od[1] !== 96'd0 || oc[1] !== 24'd0 || op[1] !== 32'd0 ||
        sc[1] !== 16'd0 || ir[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b data=%h ctrl=%h pc=%h cnt=%0d ready=%b, want 0 0 0 0 0 1",
               ov[1], od[1], oc[1], op[1], sc[1], ir[1]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h3300;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      int want;
      tick();
      want = (i < 15) ? i : 15;
      n_tests++;
      if (int'(sc2) !== want) begin
        n_fail++;
        $display("FAIL sat[%0d]: cnt4=%0d, want %0d", i, sc2, want);
      end
    end
    n_tests++;
    if (sc[1] !== 16'd20 || op[2] !== 32'h3300) begin
      n_fail++;
      $display("FAIL sat_wide: cnt16=%0d pc=%h, want 20 3300", sc[1], op[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 55);
      bubble    = ($urandom_range(0, 99) < 10);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 199) == 0);
      in_data   = {$urandom(), $urandom(), $urandom()};
      in_ctrl   = 24'($urandom());
      in_pc     = $urandom();
      #1;
      for (int k = 0; k < 3; k++) begin
        bit exp_rdy;
        exp_rdy = (mskid[k] != 0) ? (mn[k] < 2) : ((mn[k] == 0) || out_ready);
        n_tests++;
        if (ir[k] !== exp_rdy || ov[k] !== (mn[k] > 0) || dut_cnt(k) !== mcnt[k]) begin
          n_fail++;
          $display("FAIL rand c%0d dut%0d: ready=%b valid=%b cnt=%0d, want %b %b %0d",
                   c, k, ir[k], ov[k], dut_cnt(k), exp_rdy, (mn[k] > 0), mcnt[k]);
        end
        if (mn[k] > 0) begin
          n_tests++;
          if (op[k] !== mpc[k][0] || oc[k] !== mctrl[k][0] || od[k] !== mdat[k][0]) begin
            n_fail++;
            $display("FAIL rand_head c%0d dut%0d: pc=%h ctrl=%h data=%h, want %h %h %h",
                     c, k, op[k], oc[k], od[k], mpc[k][0], mctrl[k][0], mdat[k][0]);
          end
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      mn[k]   = 0;
      mcnt[k] = 0;
    end
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
